// File: rtl/ct_ciu_snb_age_mtx_pkg.sv
// Shared SAB configuration for the snoop-buffer age matrix.
// Supplies the SAB depth and the fixed count of age-vector output ports.
`ifndef SAB_DEPTH
`define SAB_DEPTH 24
`endif

package ct_ciu_snb_age_mtx_pkg;
  localparam int SAB_DEPTH = `SAB_DEPTH;
  localparam int AGE_PORTS = 24;
endpackage

// File: rtl/ct_ciu_snb_age_entry.sv
// One row of the age matrix: entry valid bit plus its "older than me" vector.
// A fresh row sees every surviving entry as older; columns drop as entries leave.
module ct_ciu_snb_age_entry #(
  parameter int DEPTH = 24,
  parameter int IDX   = 0
) (
  input  logic             forever_ciuclk,
  input  logic             cpurst_b,
  input  logic             alloc,
  input  logic             dealloc,
  input  logic [DEPTH-1:0] alloc_vec,
  input  logic [DEPTH-1:0] dealloc_vec,
  input  logic [DEPTH-1:0] entry_vld,
  output logic             vld,
  output logic [DEPTH-1:0] age_row
);

  localparam logic [DEPTH-1:0] SELF = DEPTH'(1) << IDX;

  logic             rel;
  logic [DEPTH-1:0] col_clr;

  assign rel     = dealloc & vld;
  assign col_clr = alloc_vec | (dealloc_vec & entry_vld);

  always_ff @(posedge forever_ciuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      vld     <= 1'b0;
      age_row <= '0;
    end else if (alloc) begin
      vld     <= 1'b1;
      age_row <= entry_vld & ~dealloc_vec & ~SELF;
    end else if (rel) begin
      vld     <= 1'b0;
      age_row <= '0;
    end else begin
      age_row <= age_row & ~col_clr & ~SELF;
    end
  end

endmodule

// File: rtl/ct_ciu_snb_age_mtx.sv
// Snoop-buffer age matrix: free-slot allocation and per-entry relative age.
// Row N bit j set means entry j is valid and older than entry N.
module ct_ciu_snb_age_mtx
  import ct_ciu_snb_age_mtx_pkg::*;
#(
  parameter int DEPTH = `SAB_DEPTH
) (
  input  logic             forever_ciuclk,
  input  logic             cpurst_b,
  input  logic             alloc_req,
  output logic             alloc_gnt,
  output logic [DEPTH-1:0] alloc_ptr,
  input  logic [DEPTH-1:0] dealloc_vld,
  output logic [DEPTH-1:0] entry_vld,
  output logic             full,
  output logic             empty,
  output logic [DEPTH-1:0] entry0_age_vect,
  output logic [DEPTH-1:0] entry1_age_vect,
  output logic [DEPTH-1:0] entry2_age_vect,
  output logic [DEPTH-1:0] entry3_age_vect,
  output logic [DEPTH-1:0] entry4_age_vect,
  output logic [DEPTH-1:0] entry5_age_vect,
  output logic [DEPTH-1:0] entry6_age_vect,
  output logic [DEPTH-1:0] entry7_age_vect,
  output logic [DEPTH-1:0] entry8_age_vect,
  output logic [DEPTH-1:0] entry9_age_vect,
  output logic [DEPTH-1:0] entry10_age_vect,
  output logic [DEPTH-1:0] entry11_age_vect,
  output logic [DEPTH-1:0] entry12_age_vect,
  output logic [DEPTH-1:0] entry13_age_vect,
  output logic [DEPTH-1:0] entry14_age_vect,
  output logic [DEPTH-1:0] entry15_age_vect,
  output logic [DEPTH-1:0] entry16_age_vect,
  output logic [DEPTH-1:0] entry17_age_vect,
  output logic [DEPTH-1:0] entry18_age_vect,
  output logic [DEPTH-1:0] entry19_age_vect,
  output logic [DEPTH-1:0] entry20_age_vect,
  output logic [DEPTH-1:0] entry21_age_vect,
  output logic [DEPTH-1:0] entry22_age_vect,
  output logic [DEPTH-1:0] entry23_age_vect
);

  logic [DEPTH-1:0] alloc_vec;
  logic [DEPTH-1:0] age [AGE_PORTS];

  // Lowest zero bit; naturally zero when every entry is valid.
  assign alloc_ptr = ~entry_vld & (entry_vld + DEPTH'(1));
  assign full      = &entry_vld;
  assign empty     = ~|entry_vld;
  assign alloc_gnt = alloc_req & ~full;
  assign alloc_vec = alloc_ptr & {DEPTH{alloc_gnt}};

  for (genvar i = 0; i < AGE_PORTS; i++) begin : g_row
    if (i < DEPTH) begin : g_ent
      ct_ciu_snb_age_entry #(
        .DEPTH (DEPTH),
        .IDX   (i)
      ) u_entry (
        .forever_ciuclk (forever_ciuclk),
        .cpurst_b       (cpurst_b),
        .alloc          (alloc_vec[i]),
        .dealloc        (dealloc_vld[i]),
        .alloc_vec      (alloc_vec),
        .dealloc_vec    (dealloc_vld),
        .entry_vld      (entry_vld),
        .vld            (entry_vld[i]),
        .age_row        (age[i])
      );
    end else begin : g_nil
      assign age[i] = '0;
    end
  end

  assign entry0_age_vect  = age[0];
  assign entry1_age_vect  = age[1];
  assign entry2_age_vect  = age[2];
  assign entry3_age_vect  = age[3];
  assign entry4_age_vect  = age[4];
  assign entry5_age_vect  = age[5];
  assign entry6_age_vect  = age[6];
  assign entry7_age_vect  = age[7];
  assign entry8_age_vect  = age[8];
  assign entry9_age_vect  = age[9];
  assign entry10_age_vect = age[10];
  assign entry11_age_vect = age[11];
  assign entry12_age_vect = age[12];
  assign entry13_age_vect = age[13];
  assign entry14_age_vect = age[14];
  assign entry15_age_vect = age[15];
  assign entry16_age_vect = age[16];
  assign entry17_age_vect = age[17];
  assign entry18_age_vect = age[18];
  assign entry19_age_vect = age[19];
  assign entry20_age_vect = age[20];
  assign entry21_age_vect = age[21];
  assign entry22_age_vect = age[22];
  assign entry23_age_vect = age[23];

endmodule

// File: tb/tb_ct_ciu_snb_age_mtx.sv
// Directed bench for the snoop-buffer age matrix with a stamp-based
// reference model cross-checking every row after each edge.
module tb_ct_ciu_snb_age_mtx;

  localparam int D = 24;

  logic         clk;
  logic         rst_n;
  logic         alloc_req;
  logic         alloc_gnt;
  logic [D-1:0] alloc_ptr;
  logic [D-1:0] dealloc_vld;
  logic [D-1:0] entry_vld;
  logic         full;
  logic         empty;
  logic [D-1:0] age [D];

  int n_tests = 0;
  int n_fail  = 0;

  logic [D-1:0] mvld;
  int           stamp [D];
  int           cnt;

  ct_ciu_snb_age_mtx #(.DEPTH(D)) dut (
    .forever_ciuclk   (clk),
    .cpurst_b         (rst_n),
    .alloc_req        (alloc_req),
    .alloc_gnt        (alloc_gnt),
    .alloc_ptr        (alloc_ptr),
    .dealloc_vld      (dealloc_vld),
    .entry_vld        (entry_vld),
    .full             (full),
    .empty            (empty),
    .entry0_age_vect  (age[0]),
    .entry1_age_vect  (age[1]),
    .entry2_age_vect  (age[2]),
    .entry3_age_vect  (age[3]),
    .entry4_age_vect  (age[4]),
    .entry5_age_vect  (age[5]),
    .entry6_age_vect  (age[6]),
    .entry7_age_vect  (age[7]),
    .entry8_age_vect  (age[8]),
    .entry9_age_vect  (age[9]),
    .entry10_age_vect (age[10]),
    .entry11_age_vect (age[11]),
    .entry12_age_vect (age[12]),
    .entry13_age_vect (age[13]),
    .entry14_age_vect (age[14]),
    .entry15_age_vect (age[15]),
    .entry16_age_vect (age[16]),
    .entry17_age_vect (age[17]),
    .entry18_age_vect (age[18]),
    .entry19_age_vect (age[19]),
    .entry20_age_vect (age[20]),
    .entry21_age_vect (age[21]),
    .entry22_age_vect (age[22]),
    .entry23_age_vect (age[23])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%06h expected 0x%06h", tag, obs, exp);
    end
  endtask

  function automatic logic [D-1:0] m_row(input int i);
    logic [D-1:0] r = '0;
    for (int j = 0; j < D; j++)
      r[j] = mvld[i] && mvld[j] && (stamp[j] < stamp[i]);
    return r;
  endfunction

  function automatic logic [D-1:0] m_ptr();
    for (int j = 0; j < D; j++)
      if (!mvld[j]) return D'(1) << j;
    return '0;
  endfunction

  task automatic chk_state();
    logic [D-1:0] bad = '0;
    int oldest = -1;
    int dut_old = -1;
    int n_zero = 0;
    chk("vld", 32'(entry_vld), 32'(mvld));
    chk("full", 32'(full), 32'(&mvld));
    chk("empty", 32'(empty), 32'(~|mvld));
    for (int i = 0; i < D; i++)
      if (age[i] !== m_row(i)) bad[i] = 1'b1;
    chk("rows", 32'(bad), 32'h0);
    // Oldest: valid entry with nothing older; model picks lowest stamp.
    for (int i = 0; i < D; i++) begin
      if (mvld[i] && (oldest < 0 || stamp[i] < stamp[oldest])) oldest = i;
      if (entry_vld[i] && age[i] == '0) begin
        n_zero++;
        dut_old = i;
      end
    end
    if (mvld != '0) begin
      chk("oldest_cnt", 32'(n_zero), 32'd1);
      chk("oldest", 32'(dut_old), 32'(oldest));
    end
  endtask

  task automatic tick(input logic req, input logic [D-1:0] dv);
    logic         g;
    logic [D-1:0] p;
    alloc_req   = req;
    dealloc_vld = dv;
    #1;
    g = req && !(&mvld);
    p = m_ptr();
    chk("gnt", 32'(alloc_gnt), 32'(g));
    chk("ptr", 32'(alloc_ptr), 32'(p));
    @(posedge clk);
    mvld = mvld & ~dv;
    if (g) begin
      for (int j = 0; j < D; j++)
        if (p[j]) stamp[j] = cnt;
      cnt++;
      mvld = mvld | p;
    end
    @(negedge clk);
    chk_state();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mvld  = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    alloc_req = 1'b1;
    dealloc_vld = '0;
    mvld = '0;
    cnt = 0;
    for (int i = 0; i < D; i++) stamp[i] = 0;
    @(negedge clk);
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ptr", 32'(alloc_ptr), 32'h1);
    chk("rst_gnt", 32'(alloc_gnt), 32'd1);
    chk("rst_vld", 32'(entry_vld), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Three allocations in a row
    for (int k = 0; k < 3; k++) tick(1'b1, '0);
    chk("a3_vld", 32'(entry_vld), 32'h7);
    chk("a3_age0", 32'(age[0]), 32'h0);
    chk("a3_age1", 32'(age[1]), 32'h1);
    chk("a3_age2", 32'(age[2]), 32'h3);

    // Release oldest
    tick(1'b0, 24'h000001);
    chk("d0_vld", 32'(entry_vld), 32'h6);
    chk("d0_age1", 32'(age[1]), 32'h0);
    chk("d0_age2", 32'(age[2]), 32'h2);
    chk("d0_ptr", 32'(alloc_ptr), 32'h1);

    // Alloc entry 0 while releasing entry 1
    tick(1'b1, 24'h000002);
    chk("ad_vld", 32'(entry_vld), 32'h5);
    chk("ad_age0", 32'(age[0]), 32'h4);
    chk("ad_age2", 32'(age[2]), 32'h0);

    // Invalid-entry dealloc is ignored
    tick(1'b0, 24'h000008);
    chk("inv_vld", 32'(entry_vld), 32'h5);
    chk("inv_age0", 32'(age[0]), 32'h4);

    // Fill, then release 7 while requesting: grant lands next cycle
    do_reset();
    for (int k = 0; k < D; k++) tick(1'b1, '0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ptr", 32'(alloc_ptr), 32'h0);
    alloc_req = 1'b1;
    dealloc_vld = 24'h000080;
    #1;
    chk("fill_gnt", 32'(alloc_gnt), 32'd0);
    tick(1'b1, 24'h000080);
    chk("f7_vld", 32'(entry_vld), 32'hFFFF7F);
    alloc_req = 1'b1;
    dealloc_vld = '0;
    #1;
    chk("f7_ptr", 32'(alloc_ptr), 32'h80);
    chk("f7_gnt", 32'(alloc_gnt), 32'd1);
    tick(1'b1, '0);
    chk("f7_full", 32'(full), 32'd1);
    chk("f7_age7", 32'(age[7]), 32'hFFFF7F);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      logic [D-1:0] dv;
      dv = D'($urandom & $urandom & $urandom);
      tick(1'($urandom_range(0, 1)), dv);
    end

    // Async reset mid-traffic, observed before any clock edge
    alloc_req = 1'b1;
    dealloc_vld = '0;
    #2;
    rst_n = 1'b0;
    #1;
    begin
      logic any_age = 1'b0;
      for (int i = 0; i < D; i++) any_age |= |age[i];
      chk("ar_age", 32'(any_age), 32'd0);
    end
    chk("ar_vld", 32'(entry_vld), 32'h0);
    chk("ar_empty", 32'(empty), 32'd1);
    chk("ar_full", 32'(full), 32'd0);
    chk("ar_ptr", 32'(alloc_ptr), 32'h1);
    chk("ar_gnt", 32'(alloc_gnt), 32'd1);
    mvld = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1, '0);
    chk("post_vld", 32'(entry_vld), 32'h1);
    chk("post_age0", 32'(age[0]), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
